// File: rtl/irq_timer_ctrl_pkg.sv
// Shared definitions for the interrupt/timer block and its consumers.
//   - Register byte offsets inside the 32-byte window (OFS_*).
//   - IRQ codes driven to the control unit, also used for its exception
//     vector selection (IRQ_*).
//   - Default window base address.
//   - irq_encode: fixed-priority encoder, timer > UART > key.
package irq_timer_ctrl_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    localparam logic [4:0] OFS_TH    = 5'h00;
    localparam logic [4:0] OFS_TL    = 5'h04;
    localparam logic [4:0] OFS_TCON  = 5'h08;
    localparam logic [4:0] OFS_IEN   = 5'h0C;
    localparam logic [4:0] OFS_IPEND = 5'h10;
    localparam logic [4:0] OFS_GIE   = 5'h14;

    localparam logic [1:0] IRQ_NONE  = 2'b00;
    localparam logic [1:0] IRQ_TIMER = 2'b01;
    localparam logic [1:0] IRQ_UART  = 2'b10;
    localparam logic [1:0] IRQ_KEY   = 2'b11;

    // active[0]=timer, [1]=UART, [2]=key; lowest index has priority.
    function automatic logic [1:0] irq_encode(input logic [2:0] active);
        if (active[0]) return IRQ_TIMER;
        if (active[1]) return IRQ_UART;
        if (active[2]) return IRQ_KEY;
        return IRQ_NONE;
    endfunction

endpackage

// File: rtl/irq_timer_ctrl_timer.sv
// timer_core: reloadable up-counter with run control.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   wdata_i         CPU store data for TH/TL
//   th_we_i         load TH (reload value)
//   tl_we_i         load TL (counter); overrides counting/reload
//   run_we_i        load run bit from run_wdata_i
//   th_o, tl_o      current reload and counter values
//   run_o           counter running
//   ovf_o           combinational: counter at all-ones while running,
//                   i.e. a reload happens on the coming edge
module timer_core #(
    parameter int unsigned TIMER_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [TIMER_W-1:0] wdata_i,
    input  logic               th_we_i,
    input  logic               tl_we_i,
    input  logic               run_we_i,
    input  logic               run_wdata_i,
    output logic [TIMER_W-1:0] th_o,
    output logic [TIMER_W-1:0] tl_o,
    output logic               run_o,
    output logic               ovf_o
);

    logic [TIMER_W-1:0] th_q, th_d;
    logic [TIMER_W-1:0] tl_q, tl_d;
    logic               run_q, run_d;

    assign ovf_o = run_q && (tl_q == '1);

    always_comb begin
        th_d  = th_q;
        tl_d  = tl_q;
        run_d = run_q;
        if (run_q) begin
            // Reload from TH instead of wrapping to zero.
            tl_d = ovf_o ? th_q : tl_q + TIMER_W'(1);
        end
        if (tl_we_i)  tl_d  = wdata_i;
        if (th_we_i)  th_d  = wdata_i;
        if (run_we_i) run_d = run_wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            th_q  <= '0;
            tl_q  <= '0;
            run_q <= 1'b0;
        end else begin
            th_q  <= th_d;
            tl_q  <= tl_d;
            run_q <= run_d;
        end
    end

    assign th_o  = th_q;
    assign tl_o  = tl_q;
    assign run_o = run_q;

endmodule

// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl: memory-mapped interrupt source block (timer, UART rx,
// key) producing a registered, priority-encoded 2-bit IRQ code.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   addr, wdata           data-memory byte address and store data
//   MemRead, MemWrite     load/store strobes
//   rdata                 combinational load data (0 when not selected)
//   uart_rx_done          one-cycle pulse, sets UART pending
//   key_event             one-cycle pulse, sets key pending
//   IRQ                   00 none, 01 timer, 10 UART, 11 key
module irq_timer_ctrl
    import irq_timer_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned TIMER_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rdata,
    input  logic        uart_rx_done,
    input  logic        key_event,
    output logic [1:0]  IRQ
);

    logic       hit;
    logic       we;
    logic [4:0] ofs;
    logic       unused_addr_lsbs;

    assign hit = (addr[31:5] == BASE_ADDR[31:5]);
    assign ofs = {addr[4:2], 2'b00};
    assign we  = MemWrite && hit;
    assign unused_addr_lsbs = ^addr[1:0];

    logic [TIMER_W-1:0] th;
    logic [TIMER_W-1:0] tl;
    logic               run;
    logic               ovf;

    timer_core #(
        .TIMER_W(TIMER_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .wdata_i    (wdata[TIMER_W-1:0]),
        .th_we_i    (we && (ofs == OFS_TH)),
        .tl_we_i    (we && (ofs == OFS_TL)),
        .run_we_i   (we && (ofs == OFS_TCON)),
        .run_wdata_i(wdata[0]),
        .th_o       (th),
        .tl_o       (tl),
        .run_o      (run),
        .ovf_o      (ovf)
    );

    // ien_q[0] is the single timer-enable bit seen at both TCON[1] and IEN[0].
    logic [2:0] ien_q, ien_d;
    logic [2:0] pend_q, pend_d;
    logic       gie_q, gie_d;
    logic [1:0] irq_q, irq_d;

    always_comb begin
        ien_d  = ien_q;
        pend_d = pend_q;
        gie_d  = gie_q;
        if (we) begin
            case (ofs)
                OFS_TCON:  ien_d[0] = wdata[1];
                OFS_IEN:   ien_d    = wdata[2:0];
                OFS_IPEND: pend_d   = pend_q & ~wdata[2:0];
                OFS_GIE:   gie_d    = wdata[0];
                default:   ;
            endcase
        end
        // Set after clear so a same-cycle event is never lost.
        pend_d = pend_d | {key_event, uart_rx_done, ovf};
        irq_d  = irq_encode(pend_d & ien_d & {3{gie_d}});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ien_q  <= '0;
            pend_q <= '0;
            gie_q  <= 1'b0;
            irq_q  <= IRQ_NONE;
        end else begin
            ien_q  <= ien_d;
            pend_q <= pend_d;
            gie_q  <= gie_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (MemRead && hit) begin
            case (ofs)
                OFS_TH:    rdata = 32'(th);
                OFS_TL:    rdata = 32'(tl);
                OFS_TCON:  rdata = {30'b0, ien_q[0], run};
                OFS_IEN:   rdata = {29'b0, ien_q};
                OFS_IPEND: rdata = {29'b0, pend_q};
                OFS_GIE:   rdata = {31'b0, gie_q};
                default:   rdata = '0;
            endcase
        end
    end

    assign IRQ = irq_q;

endmodule
